// File: rtl/data_load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_load_pkg
// Purpose  : Shared widths and load-type encoding for the data_load front end.
// Revision : 1.0 - initial release
// ============================================================================
package data_load_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int VEC_W     = DATA_W * NUM_WORDS;
  localparam int CNT_W     = $clog2(NUM_WORDS);

  typedef enum logic {
    LOAD_WEIGHT = 1'b0,
    LOAD_INPUT  = 1'b1
  } load_type_e;

endpackage : data_load_pkg
`default_nettype wire

// File: rtl/data_load_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : data_load_input_packer
// Purpose  : Packs NUM_WORDS streamed input words into one first-level vector.
// Revision : 1.0 - initial release
// ============================================================================
module data_load_input_packer
  import data_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [VEC_W-1:0]  vec_o,
  output logic              valid_o
);

  localparam logic [CNT_W-1:0] c_last_slot = CNT_W'(NUM_WORDS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [VEC_W-1:0] r_asm;
  logic [VEC_W-1:0] r_vec;
  logic             r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_asm   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (accept_i) begin
        r_asm[r_cnt*DATA_W +: DATA_W] <= word_i;
        if (r_cnt == c_last_slot) begin
          // Last word bypasses the assembly register so the vector lands this edge.
          r_vec   <= {word_i, r_asm[VEC_W-DATA_W-1:0]};
          r_valid <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign vec_o   = r_vec;
  assign valid_o = r_valid;

endmodule : data_load_input_packer
`default_nettype wire

// File: rtl/data_load.sv
`default_nettype none
// ============================================================================
// Module   : data_load
// Purpose  : Front-end loader: packs input words, registers weight words.
// Revision : 1.0 - initial release
// ============================================================================
module data_load
  import data_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              load_en_i,
  input  logic              load_type,
  output logic [VEC_W-1:0]  first_level_input_data,
  output logic [DATA_W-1:0] weight_o,
  output logic              weight_valid,
  output logic              input_valid
);

  logic              w_in_accept;
  logic              w_wt_accept;
  logic [DATA_W-1:0] r_weight;
  logic              r_weight_valid;

  assign w_in_accept = load_en_i && (load_type_e'(load_type) == LOAD_INPUT);
  assign w_wt_accept = load_en_i && (load_type_e'(load_type) == LOAD_WEIGHT);

  data_load_input_packer u_input_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept_i (w_in_accept),
    .word_i   (data_i),
    .vec_o    (first_level_input_data),
    .valid_o  (input_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight       <= '0;
      r_weight_valid <= 1'b0;
    end else begin
      r_weight_valid <= w_wt_accept;
      if (w_wt_accept) begin
        r_weight <= data_i;
      end
    end
  end

  assign weight_o     = r_weight;
  assign weight_valid = r_weight_valid;

endmodule : data_load
`default_nettype wire

// File: tb/tb_data_load.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_load
// Purpose  : Directed self-checking bench for data_load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_load;

  logic         clk;
  logic         rst_n;
  logic [31:0]  data_i;
  logic         load_en_i;
  logic         load_type;
  logic [255:0] first_level_input_data;
  logic [31:0]  weight_o;
  logic         weight_valid;
  logic         input_valid;

  int n_tests;
  int n_fail;

  data_load dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .data_i                 (data_i),
    .load_en_i              (load_en_i),
    .load_type              (load_type),
    .first_level_input_data (first_level_input_data),
    .weight_o               (weight_o),
    .weight_valid           (weight_valid),
    .input_valid            (input_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, and return 1ns after it for sampling.
  task automatic cycle(input logic en, input logic typ, input logic [31:0] d);
    load_en_i = en;
    load_type = typ;
    data_i    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      n_tests++;
      if ({first_level_input_data, weight_o, weight_valid, input_valid} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got vec=%h w=%h wv=%b iv=%b required all 0",
                 i, first_level_input_data, weight_o, weight_valid, input_valid);
      end
    end
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 32'h55);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 32'h60 + i);
    n_tests++;
    if (weight_o !== 32'h55 || first_level_input_data[31:0] !== 32'h60) begin
      n_fail++;
      $display("FAIL async_preload: got w=%h v0=%h required w=00000055 v0=00000060",
               weight_o, first_level_input_data[31:0]);
    end
    load_en_i = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({first_level_input_data, weight_o, weight_valid, input_valid} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got vec=%h w=%h wv=%b iv=%b required all 0",
               first_level_input_data, weight_o, weight_valid, input_valid);
    end
    cycle(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_input_burst();
    logic [255:0] exp_vec;
    exp_vec = {32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 32'd10 + i);
      n_tests++;
      if (input_valid !== (i == 7)) begin
        n_fail++;
        $display("FAIL burst_valid word%0d: got %b required %b", i, input_valid, (i == 7));
      end
      if (i < 7) begin
        n_tests++;
        if (first_level_input_data !== '0) begin
          n_fail++;
          $display("FAIL burst_partial word%0d: got %h required 0", i, first_level_input_data);
        end
      end
    end
    n_tests++;
    if (first_level_input_data !== exp_vec) begin
      n_fail++;
      $display("FAIL burst_vec: got %h required %h", first_level_input_data, exp_vec);
    end
  endtask

  task automatic test_weight_stream();
    logic [255:0] held;
    held = {32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'd20 + i);
      n_tests++;
      if (weight_o !== 32'd20 + i || weight_valid !== 1'b1 || input_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL weight_word%0d: got w=%0d wv=%b iv=%b required w=%0d wv=1 iv=0",
                 i, weight_o, weight_valid, input_valid, 20 + i);
      end
    end
    cycle(1'b0, 1'b0, 32'hDEAD);
    n_tests++;
    if (weight_valid !== 1'b0 || weight_o !== 32'd27 || first_level_input_data !== held) begin
      n_fail++;
      $display("FAIL weight_idle: got wv=%b w=%0d vec=%h required wv=0 w=27 vec held",
               weight_valid, weight_o, first_level_input_data);
    end
  endtask

  task automatic test_interleave();
    logic [255:0] exp_vec;
    int wv_cnt, iv_cnt;
    wv_cnt = 0;
    iv_cnt = 0;
    exp_vec = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b1, i);
      wv_cnt += int'(weight_valid);
      iv_cnt += int'(input_valid);
    end
    cycle(1'b1, 1'b0, 32'hAA);
    wv_cnt += int'(weight_valid);
    n_tests++;
    if (weight_o !== 32'hAA) begin
      n_fail++;
      $display("FAIL inter_wAA: got %h required 000000aa", weight_o);
    end
    cycle(1'b1, 1'b0, 32'hBB);
    wv_cnt += int'(weight_valid);
    n_tests++;
    if (weight_o !== 32'hBB) begin
      n_fail++;
      $display("FAIL inter_wBB: got %h required 000000bb", weight_o);
    end
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    wv_cnt += int'(weight_valid);
    iv_cnt += int'(input_valid);
    for (int i = 5; i <= 8; i++) begin
      cycle(1'b1, 1'b1, i);
      wv_cnt += int'(weight_valid);
      if (i < 8) iv_cnt += int'(input_valid);
    end
    n_tests++;
    if (input_valid !== 1'b1 || iv_cnt != 0) begin
      n_fail++;
      $display("FAIL inter_ivalid: got last=%b early_pulses=%0d required last=1 early=0",
               input_valid, iv_cnt);
    end
    n_tests++;
    if (wv_cnt != 2) begin
      n_fail++;
      $display("FAIL inter_wvalid_count: got %0d required 2", wv_cnt);
    end
    n_tests++;
    if (first_level_input_data !== exp_vec) begin
      n_fail++;
      $display("FAIL inter_vec: got %h required %h", first_level_input_data, exp_vec);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] exp_vec;
    int iv_cnt;
    iv_cnt = 0;
    exp_vec = {32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100};
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 32'h50 + i);
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 32'h100 + i);
      iv_cnt += int'(input_valid);
    end
    n_tests++;
    if (iv_cnt != 1 || input_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pulses: got count=%0d last=%b required count=1 last=1",
               iv_cnt, input_valid);
    end
    n_tests++;
    if (first_level_input_data !== exp_vec) begin
      n_fail++;
      $display("FAIL midrst_vec: got %h required %h", first_level_input_data, exp_vec);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_a, exp_b;
    int first_at, second_at, pulses;
    first_at  = -1;
    second_at = -1;
    pulses    = 0;
    exp_a = {32'h207, 32'h206, 32'h205, 32'h204, 32'h203, 32'h202, 32'h201, 32'h200};
    exp_b = {32'h20F, 32'h20E, 32'h20D, 32'h20C, 32'h20B, 32'h20A, 32'h209, 32'h208};
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 32'h200 + i);
      if (input_valid === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          n_tests++;
          if (first_level_input_data !== exp_a) begin
            n_fail++;
            $display("FAIL b2b_vec_a: got %h required %h", first_level_input_data, exp_a);
          end
        end else begin
          second_at = i;
          n_tests++;
          if (first_level_input_data !== exp_b) begin
            n_fail++;
            $display("FAIL b2b_vec_b: got %h required %h", first_level_input_data, exp_b);
          end
        end
      end
    end
    n_tests++;
    if (pulses != 2 || first_at != 7 || second_at != 15) begin
      n_fail++;
      $display("FAIL b2b_timing: got pulses=%0d at %0d,%0d required 2 at 7,15",
               pulses, first_at, second_at);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_tests++;
    if (input_valid !== 1'b0 || first_level_input_data !== exp_b) begin
      n_fail++;
      $display("FAIL b2b_hold: got iv=%b vec=%h required iv=0 vec=%h",
               input_valid, first_level_input_data, exp_b);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    load_en_i = 1'b0;
    load_type = 1'b0;
    data_i    = '0;
    test_reset();
    test_input_burst();
    test_weight_stream();
    test_interleave();
    test_reset_mid_burst();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_data_load
`default_nettype wire
